// File: rtl/div_pkg.sv
// Shared types and sizing for the iterative radix-2 restoring divider.
package div_pkg;
    localparam int DIV_WIDTH = 64;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } div_state_t;
endpackage

// File: rtl/div_if.sv
// Start/busy/done handshake and operand/result bundle between EX control and the divider.
interface div_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             doSigned;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             divByZero;

    modport master (
        output start, A, B, doSigned,
        input  busy, done, quotient, remainder, divByZero
    );

    modport slave (
        input  start, A, B, doSigned,
        output busy, done, quotient, remainder, divByZero
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, restore on borrow.
module div_step #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH:0]   rem,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic             q_bit
);
    logic [WIDTH+1:0] diff;

    // One extra bit beyond the partial remainder so the borrow is visible as the sign.
    assign diff     = {rem, dvd_bit} - {2'b00, divisor};
    assign q_bit    = ~diff[WIDTH+1];
    assign rem_next = q_bit ? diff[WIDTH:0] : {rem[WIDTH-1:0], dvd_bit};
endmodule

// File: rtl/div.sv
// Iterative UDIV/SDIV for the EX stage: one quotient bit per cycle, sign fix-up at the end.
module div
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input logic  clk,
    input logic  reset,
    div_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    div_state_t       state;
    div_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   prem;
    logic             q_neg;
    logic             r_neg;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   step_rem;
    logic             step_q;
    logic             can_start;

    assign a_neg     = bus.doSigned & bus.A[WIDTH-1];
    assign b_neg     = bus.doSigned & bus.B[WIDTH-1];
    assign a_mag     = a_neg ? -bus.A : bus.A;
    assign b_mag     = b_neg ? -bus.B : bus.B;
    assign can_start = (state == IDLE) || (state == DONE);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (prem),
        .dvd_bit  (dvd[WIDTH-1]),
        .divisor  (dvs),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (!bus.start)          state_next = IDLE;
                else if (bus.B == '0)    state_next = DONE;
                else                     state_next = CALC;
            end
            CALC:    if (cnt == '0) state_next = FIXUP;
            FIXUP:   state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == CALC) || (state == FIXUP);
        bus.done = (state == DONE);
    end

    // The dividend register doubles as the quotient accumulator as bits shift out.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            dvd         <= '0;
            dvs         <= '0;
            prem        <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        if (bus.B == '0) begin
                            quotient_q  <= '0;
                            remainder_q <= bus.A;
                            dbz_q       <= 1'b1;
                        end else begin
                            dvd   <= a_mag;
                            dvs   <= b_mag;
                            q_neg <= a_neg ^ b_neg;
                            r_neg <= a_neg;
                            prem  <= '0;
                            cnt   <= CNT_W'(WIDTH - 1);
                        end
                    end
                end
                CALC: begin
                    prem <= step_rem;
                    dvd  <= {dvd[WIDTH-2:0], step_q};
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                FIXUP: begin
                    // MIN / -1 needs no special case: 2^(WIDTH-1) negates to itself.
                    quotient_q  <= q_neg ? -dvd : dvd;
                    remainder_q <= r_neg ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
                    dbz_q       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.divByZero = dbz_q;
endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for the 64-bit iterative divider.
module tb_div;
    import div_pkg::*;

    localparam int W = 64;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    div_if #(.WIDTH(W)) bus ();

    div #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Caller sits at a negedge; returns at the negedge of the cycle where done is seen.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output int lat, output int busy_cnt);
        bus.A        = a;
        bus.B        = b;
        bus.doSigned = s;
        bus.start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        lat       = 1;
        busy_cnt  = 0;
        while (bus.done !== 1'b1 && lat < 200) begin
            if (bus.busy === 1'b1) busy_cnt++;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({bus.busy, bus.done, bus.divByZero} !== 3'b000 || bus.quotient !== '0 || bus.remainder !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: busy=%b done=%b dbz=%b q=%h r=%h, required all zero",
                     bus.busy, bus.done, bus.divByZero, bus.quotient, bus.remainder);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_unsigned();
        int lat, bc;
        do_op(64'd100, 64'd7, 1'b0, lat, bc);
        tests_run++;
        if (lat !== 66) begin
            tests_failed++;
            $display("FAIL udiv_latency: got %0d, required 66", lat);
        end
        tests_run++;
        if (bc !== 65 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL udiv_busy: busy cycles %0d busy_at_done %b, required 65 and 0", bc, bus.busy);
        end
        tests_run++;
        if (bus.quotient !== 64'd14 || bus.remainder !== 64'd2 || bus.divByZero !== 1'b0) begin
            tests_failed++;
            $display("FAIL udiv_100_7: q=%0d r=%0d dbz=%b, required 14 2 0",
                     bus.quotient, bus.remainder, bus.divByZero);
        end
        @(negedge clk);
        tests_run++;
        if (bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_pulse_width: done=%b one cycle after DONE, required 0", bus.done);
        end
    endtask

    task automatic test_signed();
        int lat, bc;
        do_op(64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1, lat, bc);
        tests_run++;
        if (bus.quotient !== 64'hFFFF_FFFF_FFFF_FFF2 || bus.remainder !== 64'hFFFF_FFFF_FFFF_FFFE || lat !== 66) begin
            tests_failed++;
            $display("FAIL sdiv_m100_7: q=%h r=%h lat=%0d, required fffffffffffffff2 fffffffffffffffe 66",
                     bus.quotient, bus.remainder, lat);
        end
        @(negedge clk);
        do_op(64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, lat, bc);
        tests_run++;
        if (bus.quotient !== 64'hFFFF_FFFF_FFFF_FFF2 || bus.remainder !== 64'd2) begin
            tests_failed++;
            $display("FAIL sdiv_100_m7: q=%h r=%h, required fffffffffffffff2 0000000000000002",
                     bus.quotient, bus.remainder);
        end
        @(negedge clk);
    endtask

    task automatic test_wide();
        int lat, bc;
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, lat, bc);
        tests_run++;
        if (bus.quotient !== 64'h7FFF_FFFF_FFFF_FFFF || bus.remainder !== 64'd1) begin
            tests_failed++;
            $display("FAIL udiv_max_2: q=%h r=%h, required 7fffffffffffffff 1", bus.quotient, bus.remainder);
        end
        @(negedge clk);
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, lat, bc);
        tests_run++;
        if (bus.quotient !== 64'd0 || bus.remainder !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            tests_failed++;
            $display("FAIL sdiv_m1_2: q=%h r=%h, required 0 ffffffffffffffff", bus.quotient, bus.remainder);
        end
        @(negedge clk);
        do_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, lat, bc);
        tests_run++;
        if (bus.quotient !== 64'h8000_0000_0000_0000 || bus.remainder !== 64'd0) begin
            tests_failed++;
            $display("FAIL sdiv_min_m1: q=%h r=%h, required 8000000000000000 0", bus.quotient, bus.remainder);
        end
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        int lat, bc;
        for (int s = 0; s < 2; s++) begin
            do_op(64'd7, 64'd0, s[0], lat, bc);
            tests_run++;
            if (lat !== 1 || bc !== 0 || bus.busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL dbz_timing signed=%0d: lat=%0d busy_cycles=%0d busy=%b, required 1 0 0",
                         s, lat, bc, bus.busy);
            end
            tests_run++;
            if (bus.quotient !== 64'd0 || bus.remainder !== 64'd7 || bus.divByZero !== 1'b1) begin
                tests_failed++;
                $display("FAIL dbz_result signed=%0d: q=%0d r=%0d dbz=%b, required 0 7 1",
                         s, bus.quotient, bus.remainder, bus.divByZero);
            end
            @(negedge clk);
            tests_run++;
            if (bus.divByZero !== 1'b1 || bus.remainder !== 64'd7) begin
                tests_failed++;
                $display("FAIL dbz_hold signed=%0d: dbz=%b r=%0d, required 1 7", s, bus.divByZero, bus.remainder);
            end
        end
        do_op(64'd9, 64'd3, 1'b0, lat, bc);
        tests_run++;
        if (bus.quotient !== 64'd3 || bus.remainder !== 64'd0 || bus.divByZero !== 1'b0 || lat !== 66) begin
            tests_failed++;
            $display("FAIL after_dbz_9_3: q=%0d r=%0d dbz=%b lat=%0d, required 3 0 0 66",
                     bus.quotient, bus.remainder, bus.divByZero, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_busy();
        int lat;
        int extra_done;
        bus.A        = 64'd1000;
        bus.B        = 64'd10;
        bus.doSigned = 1'b0;
        bus.start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        lat       = 1;
        repeat (19) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        bus.A     = 64'd5;
        bus.B     = 64'd1;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lat++;
        bus.start = 1'b0;
        while (bus.done !== 1'b1 && lat < 200) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        tests_run++;
        if (bus.quotient !== 64'd100 || bus.remainder !== 64'd0 || lat !== 66) begin
            tests_failed++;
            $display("FAIL ignore_busy_start: q=%0d r=%0d lat=%0d, required 100 0 66",
                     bus.quotient, bus.remainder, lat);
        end
        extra_done = 0;
        repeat (70) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) extra_done++;
        end
        tests_run++;
        if (extra_done !== 0 || bus.quotient !== 64'd100) begin
            tests_failed++;
            $display("FAIL not_queued: activity cycles=%0d q=%0d, required 0 100", extra_done, bus.quotient);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        do_op(64'd20, 64'd4, 1'b0, lat, bc);
        tests_run++;
        if (bus.quotient !== 64'd5 || bus.remainder !== 64'd0) begin
            tests_failed++;
            $display("FAIL b2b_first: q=%0d r=%0d, required 5 0", bus.quotient, bus.remainder);
        end
        do_op(64'd83, 64'd9, 1'b0, lat, bc);
        tests_run++;
        if (bus.quotient !== 64'd9 || bus.remainder !== 64'd2 || lat !== 66 || bc !== 65) begin
            tests_failed++;
            $display("FAIL b2b_second: q=%0d r=%0d lat=%0d busy_cycles=%0d, required 9 2 66 65",
                     bus.quotient, bus.remainder, lat, bc);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        int stray;
        bus.A        = 64'd1000;
        bus.B        = 64'd3;
        bus.doSigned = 1'b0;
        bus.start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (29) begin
            @(posedge clk);
            @(negedge clk);
        end
        tests_run++;
        if (bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_calc_busy: busy=%b, required 1", bus.busy);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tests_run++;
        if ({bus.busy, bus.done, bus.divByZero} !== 3'b000 || bus.quotient !== '0 || bus.remainder !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_calc: busy=%b done=%b dbz=%b q=%h r=%h, required all zero",
                     bus.busy, bus.done, bus.divByZero, bus.quotient, bus.remainder);
        end
        stray = 0;
        repeat (70) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) stray++;
        end
        tests_run++;
        if (stray !== 0) begin
            tests_failed++;
            $display("FAIL reset_discard: activity cycles after reset=%0d, required 0", stray);
        end
        do_op(64'd50, 64'd5, 1'b0, lat, bc);
        tests_run++;
        if (bus.quotient !== 64'd10 || bus.remainder !== 64'd0 || lat !== 66) begin
            tests_failed++;
            $display("FAIL after_reset_50_5: q=%0d r=%0d lat=%0d, required 10 0 66",
                     bus.quotient, bus.remainder, lat);
        end
        @(negedge clk);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.A        = '0;
        bus.B        = '0;
        bus.doSigned = 1'b0;
        @(negedge clk);
        test_reset();
        test_unsigned();
        test_signed();
        test_wide();
        test_div_zero();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
